// File: rtl/ahb_mailbox.sv
// ahb_mailbox
// ----------------------------------------------------------------------------
// Simulation "mailbox" on AHB-Lite. Software writes single bytes to MBOX_ADDR:
// printable bytes (0x07..0x7E) are queued in a character FIFO for a console
// consumer, 0xFF ends the run with PASS, 0x01 ends it with FAIL. A read of
// MBOX_ADDR returns {cycle_cnt, 30'b0, status_code}.
//
// Optional feature macro: MBOX_TIMEOUT_EN
//   defined   -> the run ends in TIMEOUT once MAX_CYCLES cycles were spent in RUN
//   undefined -> no timeout, cycle_cnt wraps at 2^32, status_code never 3
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   HSEL..HREADY    AHB-Lite slave inputs (HSIZE ignored)
//   HREADYOUT       low only while a printable write waits for a FIFO slot
//   HRESP           always OKAY
//   HRDATA          mailbox status on reads of MBOX_ADDR, else zero
//   char_valid/char_data/char_ready   FIFO head and pop handshake
//   finished        high in any terminal state
//   status_code     0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT
//   cycle_cnt       cycles spent in RUN
// ----------------------------------------------------------------------------
module ahb_mailbox #(
  parameter logic [31:0] MBOX_ADDR  = 32'hD0580000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MAX_CYCLES = 32'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [63:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [63:0] HRDATA,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        finished,
  output logic [1:0]  status_code,
  output logic [31:0] cycle_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic        dp_wr_q, dp_wr_d;     // data phase of a write to MBOX_ADDR
  logic        dp_rd_q, dp_rd_d;     // data phase of a read of MBOX_ADDR
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       accept;
  logic       addr_hit;
  logic [7:0] wr_byte;
  logic       printable;
  logic       in_run;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       stall;

  // Bits that carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{HSIZE, HTRANS[0], HWDATA[63:8]};

`ifndef MBOX_TIMEOUT_EN
  logic [31:0] unused_max;
  assign unused_max = MAX_CYCLES;
`endif

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign addr_hit  = (HADDR == MBOX_ADDR);
  assign wr_byte   = HWDATA[7:0];
  assign printable = (wr_byte > 8'h06) && (wr_byte < 8'h7F);
  assign in_run    = (state_q == ST_RUN);
  assign fifo_full = (count_q == FULL_CNT);

  assign char_valid = (count_q != '0);
  // Head is read asynchronously so the consumer sees it the cycle it lands;
  // gated so the output is a clean zero while the FIFO is empty.
  assign char_data  = char_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop        = char_valid & char_ready;

  // A pop in the same cycle frees the slot the stalled byte needs, so a full
  // FIFO only stalls when nobody is draining it.
  assign stall = dp_wr_q & in_run & printable & fifo_full & ~pop;
  assign push  = dp_wr_q & in_run & printable & ~stall;

  assign HREADYOUT   = ~stall;
  assign HRESP       = 1'b0;
  assign HRDATA      = dp_rd_q ? {cycle_cnt_q, 30'b0, state_q} : 64'h0;
  assign finished    = (state_q != ST_RUN);
  assign status_code = state_q;
  assign cycle_cnt   = cycle_cnt_q;

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    dp_wr_d     = dp_wr_q;
    dp_rd_d     = dp_rd_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // Data-phase tracking only advances when the bus moves on.
    if (HREADY) begin
      dp_wr_d = accept & HWRITE & addr_hit;
      dp_rd_d = accept & ~HWRITE & addr_hit;
    end

    case (state_q)
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        // Control bytes never stall, so they complete in this cycle and win
        // over a timeout expiring at the same edge.
        if (dp_wr_q && wr_byte == 8'hFF) begin
          state_d = ST_PASS;
        end else if (dp_wr_q && wr_byte == 8'h01) begin
          state_d = ST_FAIL;
`ifdef MBOX_TIMEOUT_EN
        end else if (cycle_cnt_q == MAX_CYCLES - 32'd1) begin
          state_d = ST_TIMEOUT;
`endif
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_cnt_q <= 32'd0;
      dp_wr_q     <= 1'b0;
      dp_rd_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      dp_wr_q     <= dp_wr_d;
      dp_rd_q     <= dp_rd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_byte;
  end

endmodule

// File: tb/tb_ahb_mailbox.sv
`timescale 1ns/1ps
module tb_ahb_mailbox;

  localparam logic [31:0] MBOX   = 32'hD0580000;
  localparam logic [31:0] TB_MAX = 32'h800;

  logic        clk = 1'b0;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        finished;
  logic [1:0]  status_code;
  logic [31:0] cycle_cnt;

  ahb_mailbox #(
    .MBOX_ADDR (MBOX),
    .FIFO_DEPTH(8),
    .MAX_CYCLES(TB_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .finished   (finished),
    .status_code(status_code),
    .cycle_cnt  (cycle_cnt)
  );

  // Single-slave bus: the interconnect ready is our own ready.
  assign HREADY = HREADYOUT;

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         tb_cyc = 0;      // cycles since reset release == expected cycle_cnt in RUN
  logic [7:0] sb[$];           // bytes expected to leave the FIFO, in order
  logic [1:0] model_st = 2'd0; // expected status_code

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    tb_cyc++;
  endtask

  task automatic bus_idle;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
  endtask

  task automatic set_wdata(input logic [7:0] b);
    HWDATA      = {$urandom, $urandom};
    HWDATA[7:0] = b;
  endtask

  task automatic check_reset_values;
    check("rst_status",   64'(status_code), 64'd0);
    check("rst_finished", 64'(finished),    64'd0);
    check("rst_cycle",    64'(cycle_cnt),   64'd0);
    check("rst_valid",    64'(char_valid),  64'd0);
    check("rst_char",     64'(char_data),   64'd0);
    check("rst_hready",   64'(HREADYOUT),   64'd1);
    check("rst_hrdata",   HRDATA,           64'd0);
    check("rst_hresp",    64'(HRESP),       64'd0);
  endtask

  task automatic do_reset;
    bus_idle();
    rst = 1'b1;
    repeat (2) tick();
    check_reset_values();
    sb.delete();
    model_st = 2'd0;
    rst      = 1'b0;
    tb_cyc   = 0;
  endtask

  // Full write transfer; updates the scoreboard and model, returns wait states.
  task automatic ahb_write(input logic [31:0] addr, input logic [7:0] b, output int stalls);
    if (addr == MBOX && model_st == 2'd0) begin
      if (b > 8'h06 && b < 8'h7F) sb.push_back(b);
      else if (b == 8'hFF)        model_st = 2'd1;
      else if (b == 8'h01)        model_st = 2'd2;
    end
    addr_phase(addr, 1'b1);
    tick();
    bus_idle();
    set_wdata(b);
    stalls = 0;
    while (!HREADYOUT && stalls < 64) begin
      tick();
      stalls++;
    end
    if (!HREADYOUT) check("write_stall_bound", 64'(HREADYOUT), 64'd1);
    tick();
    $display("write addr=%h byte=%h stalls=%0d status=%0d", addr, b, stalls, status_code);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] b);
    int s;
    ahb_write(addr, b, s);
    check("write_zero_wait", 64'(s), 64'd0);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [63:0] data, output int cyc);
    addr_phase(addr, 1'b0);
    tick();
    bus_idle();
    data = HRDATA;
    cyc  = tb_cyc;
    check("read_zero_wait", 64'(HREADYOUT), 64'd1);
    tick();
    $display("read  addr=%h data=%h", addr, data);
  endtask

  // Pop monitor: a pop happens at the next edge, compare head to scoreboard.
  always @(negedge clk) begin
    if (!rst && char_valid && char_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 64'(char_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("pop_char", 64'(char_data), 64'(e));
        $display("pop   char=%h", char_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int          rc;
    rst        = 1'b1;
    HADDR      = 32'h0;
    HSIZE      = 3'b000;
    HWDATA     = 64'h0;
    char_ready = 1'b0;
    bus_idle();
    @(posedge clk);
    #1;

    // Two characters, consumer always ready.
    do_reset();
    char_ready = 1'b1;
    wr(MBOX, 8'h48);
    wr(MBOX, 8'h69);
    repeat (3) tick();
    check("hi_drained", 64'(sb.size()), 64'd0);
    check("hi_valid",   64'(char_valid), 64'd0);
    check("hi_status",  64'(status_code), 64'd0);
    ahb_read(MBOX, rd, rc);
    check("run_hrdata", rd, {32'(rc), 30'b0, 2'd0});

    // Non-printable / boundary bytes and foreign addresses.
    wr(MBOX, 8'h05);
    wr(MBOX, 8'h06);
    wr(MBOX, 8'h7F);
    wr(MBOX, 8'h07);
    wr(MBOX, 8'h7E);
    wr(MBOX + 32'd8, 8'h41);
    ahb_read(MBOX + 32'd8, rd, rc);
    check("other_read", rd, 64'h0);
    repeat (3) tick();
    check("ign_drained", 64'(sb.size()), 64'd0);
    check("ign_valid",   64'(char_valid), 64'd0);
    check("ign_status",  64'(status_code), 64'd0);

    // Fill the FIFO, stall the 9th write, release with one pop.
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(MBOX, 8'h41 + 8'(i));
    check("full_head", 64'(char_data), 64'h41);
    sb.push_back(8'h49);
    addr_phase(MBOX, 1'b1);
    tick();
    bus_idle();
    set_wdata(8'h49);
    check("stall_9th_a", 64'(HREADYOUT), 64'd0);
    tick();
    check("stall_9th_b", 64'(HREADYOUT), 64'd0);
    char_ready = 1'b1;
    #1;
    check("stall_release", 64'(HREADYOUT), 64'd1);
    tick();
    char_ready = 1'b0;
    check("after_release_head", 64'(char_data), 64'h42);
    // Still full: a write coinciding with a pop must not stall.
    sb.push_back(8'h4A);
    addr_phase(MBOX, 1'b1);
    tick();
    bus_idle();
    set_wdata(8'h4A);
    char_ready = 1'b1;
    #1;
    check("push_pop_full", 64'(HREADYOUT), 64'd1);
    tick();
    repeat (12) tick();
    check("full_drained", 64'(sb.size()), 64'd0);
    check("full_valid",   64'(char_valid), 64'd0);

    // PASS written in cycle 100.
    do_reset();
    char_ready = 1'b0;
    wr(MBOX, 8'h50);
    wr(MBOX, 8'h51);
    while (tb_cyc < 99) tick();
    check("cnt_99", 64'(cycle_cnt), 64'd99);
    addr_phase(MBOX, 1'b1);
    tick();
    bus_idle();
    set_wdata(8'hFF);
    check("cnt_100", 64'(cycle_cnt), 64'd100);
    tick();
    model_st = 2'd1;
    check("pass_status",   64'(status_code), 64'd1);
    check("pass_finished", 64'(finished),    64'd1);
    check("pass_cnt",      64'(cycle_cnt),   64'd101);
    repeat (5) tick();
    check("pass_cnt_frozen", 64'(cycle_cnt), 64'd101);
    ahb_read(MBOX, rd, rc);
    check("pass_hrdata", rd, {32'd101, 30'b0, 2'd1});
    wr(MBOX, 8'h41);
    wr(MBOX, 8'h01);
    check("pass_sticky", 64'(status_code), 64'd1);
    char_ready = 1'b1;
    repeat (4) tick();
    check("pass_drained", 64'(sb.size()), 64'd0);
    check("pass_valid",   64'(char_valid), 64'd0);

    // FAIL, later printable ignored, then reset.
    do_reset();
    char_ready = 1'b0;
    wr(MBOX, 8'h43);
    wr(MBOX, 8'h01);
    check("fail_status",   64'(status_code), 64'd2);
    check("fail_finished", 64'(finished),    64'd1);
    wr(MBOX, 8'h41);
    check("fail_head",  64'(char_data),  64'h43);
    check("fail_sb",    64'(sb.size()),  64'd1);
    do_reset();
    check("post_rst_valid",  64'(char_valid),  64'd0);
    check("post_rst_status", 64'(status_code), 64'd0);

    // Reset during a stall.
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(MBOX, 8'h60 + 8'(i));
    addr_phase(MBOX, 1'b1);
    tick();
    bus_idle();
    set_wdata(8'h68);
    check("rst_stall_pre", 64'(HREADYOUT), 64'd0);
    rst = 1'b1;
    tick();
    check("rst_stall_rel",   64'(HREADYOUT),  64'd1);
    check("rst_stall_empty", 64'(char_valid), 64'd0);
    do_reset();
    char_ready = 1'b1;
    repeat (3) tick();
    check("rst_stall_dropped", 64'(char_valid), 64'd0);

`ifdef MBOX_TIMEOUT_EN
    // PASS landing on the expiry cycle beats the timeout.
    do_reset();
    while (tb_cyc < int'(TB_MAX) - 2) tick();
    addr_phase(MBOX, 1'b1);
    tick();
    bus_idle();
    set_wdata(8'hFF);
    tick();
    check("to_pass_prio", 64'(status_code), 64'd1);
    // Plain timeout.
    do_reset();
    while (tb_cyc < int'(TB_MAX) - 1) tick();
    check("to_not_yet", 64'(status_code), 64'd0);
    tick();
    check("to_status",   64'(status_code), 64'd3);
    check("to_finished", 64'(finished),    64'd1);
    check("to_cnt",      64'(cycle_cnt),   64'(TB_MAX));
    repeat (3) tick();
    check("to_cnt_frozen", 64'(cycle_cnt), 64'(TB_MAX));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
